// File: rtl/ddr_cmd_sched_if.sv
// Client request and DDR command-bus bundle for ddr_cmd_sched.
// Latency: none, wires only.
// Backpressure: req_i is held by the client until ack_o pulses.
//
// Signals:
//   req_i/req_we_i/req_addr_i  client request, {bank,row,col}
//   ack_o                      one-cycle pulse with the READ/WRITE command
//   init_done_o                power-up sequence finished
//   ctl_*                      command side of the DDR IOB
//   wr_phase_o/rd_phase_o      datapath drive/capture strobes
// Modports: master = client/IOB side, slave = scheduler.
interface ddr_cmd_sched_if #(
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 10
);
    logic                          req_i;
    logic                          req_we_i;
    logic [BA_W+ROW_W+COL_W-1:0]   req_addr_i;
    logic                          ack_o;
    logic                          init_done_o;
    logic                          ctl_ce_o;
    logic                          ctl_cke_o;
    logic                          ctl_cs_no;
    logic                          ctl_ras_no;
    logic                          ctl_cas_no;
    logic                          ctl_we_no;
    logic [BA_W-1:0]               ctl_ba_o;
    logic [ROW_W-1:0]              ctl_a_o;
    logic                          wr_phase_o;
    logic                          rd_phase_o;

    modport master (
        output req_i, req_we_i, req_addr_i,
        input  ack_o, init_done_o, ctl_ce_o, ctl_cke_o,
        input  ctl_cs_no, ctl_ras_no, ctl_cas_no, ctl_we_no,
        input  ctl_ba_o, ctl_a_o, wr_phase_o, rd_phase_o
    );

    modport slave (
        input  req_i, req_we_i, req_addr_i,
        output ack_o, init_done_o, ctl_ce_o, ctl_cke_o,
        output ctl_cs_no, ctl_ras_no, ctl_cas_no, ctl_we_no,
        output ctl_ba_o, ctl_a_o, wr_phase_o, rd_phase_o
    );
endinterface

// File: rtl/ddr_cmd_sched.sv
// DDR command sequencer: power-up/mode-register init, periodic refresh, closed-page single-burst access.
// Latency: all outputs registered; ACT is issued 2 cycles after IDLE sees req_i, RD/WR follows T_RCD later.
// Backpressure: req_i must be held until ack_o; it is only sampled in IDLE and loses to a pending refresh.
//
// Ports:
//   clock_i   system clock
//   reset_ni  asynchronous active-low reset
//   bus       ddr_cmd_sched_if.slave: client request/ack, ctl_* command lines, data-phase strobes
module ddr_cmd_sched #(
    parameter int               BA_W     = 2,
    parameter int               ROW_W    = 13,
    parameter int               COL_W    = 10,
    parameter logic [ROW_W-1:0] MODE_REG = 'h022,
    parameter int               CL       = 2,
    parameter int               T_INIT   = 20000,
    parameter int               T_RP     = 2,
    parameter int               T_RFC    = 9,
    parameter int               T_MRD    = 2,
    parameter int               T_DLL    = 200,
    parameter int               T_RCD    = 2,
    parameter int               T_WRAP   = 5,
    parameter int               T_RDAP   = 4,
    parameter int               T_REFI   = 1560
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    ddr_cmd_sched_if.slave     bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_LAST = max2(T_MRD, T_DLL);
    localparam int T_MAX  = max2(max2(T_INIT, T_LAST),
                                 max2(T_RFC, max2(max2(T_WRAP, T_RDAP), max2(T_RP, T_RCD))));
    localparam int WAIT_W = $clog2(T_MAX + 1);
    localparam int REF_W  = $clog2(T_REFI + 1);

    // A command state and the wait-exit cycle each take one clock, so the
    // counter is loaded with gap-2 to place the next command exactly gap
    // cycles later.
    localparam logic [WAIT_W-1:0] W_INIT = WAIT_W'(T_INIT - 2);
    localparam logic [WAIT_W-1:0] W_RP   = WAIT_W'(T_RP - 2);
    localparam logic [WAIT_W-1:0] W_MRD  = WAIT_W'(T_MRD - 2);
    localparam logic [WAIT_W-1:0] W_RFC  = WAIT_W'(T_RFC - 2);
    localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(T_LAST - 2);
    localparam logic [WAIT_W-1:0] W_RCD  = WAIT_W'(T_RCD - 2);
    localparam logic [WAIT_W-1:0] W_WRAP = WAIT_W'(T_WRAP - 2);
    localparam logic [WAIT_W-1:0] W_RDAP = WAIT_W'(T_RDAP - 2);

    localparam logic [REF_W-1:0]  REF_RELOAD = REF_W'(T_REFI - 1);

    localparam logic [ROW_W-1:0]  A10     = ROW_W'(1) << 10;
    localparam logic [ROW_W-1:0]  DLL_RST = ROW_W'(1) << 8;

    // {cs, ras, cas, we}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    typedef enum logic [3:0] {
        S_PWRUP, S_CKE, S_PRE1, S_EMR, S_MRS_DLL, S_PRE2, S_REF1, S_REF2,
        S_MRS, S_IDLE, S_REF, S_ACT, S_RW, S_WAIT
    } state_t;

    state_t state_q, state_d;
    state_t after_q, after_d;

    logic [WAIT_W-1:0] wait_q;
    logic              wait_ld;
    logic [WAIT_W-1:0] wait_val;

    logic [BA_W-1:0]   req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [BA_W-1:0]   bank_q;
    logic [COL_W-1:0]  col_q;
    logic              we_q;
    logic              lat_en;

    logic [REF_W-1:0]  ref_cnt_q;
    logic              ref_run_q;
    logic              ref_tick;
    logic              pend_q;
    logic              pend_clr;

    logic [1:0]        wr_sh_q;
    logic [CL:0]       rd_sh_q;
    logic              wr_issue;
    logic              rd_issue;

    logic [3:0]        cmd_d, cmd_q;
    logic [BA_W-1:0]   ba_d, ba_q;
    logic [ROW_W-1:0]  a_d, a_q;
    logic              cke_d, cke_q;
    logic              ack_d, ack_q;
    logic              init_d, init_q;
    logic              ce_q;
    logic              wr_ph_q, rd_ph_q;

    assign req_bank = bus.req_addr_i[BA_W+ROW_W+COL_W-1 -: BA_W];
    assign req_row  = bus.req_addr_i[ROW_W+COL_W-1 -: ROW_W];
    assign req_col  = bus.req_addr_i[COL_W-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_PWRUP;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWRUP:   if (wait_q == '0) state_d = S_CKE;
            S_CKE:     state_d = S_PRE1;
            S_IDLE: begin
                if (pend_q)          state_d = S_REF;
                else if (bus.req_i)  state_d = S_ACT;
            end
            S_WAIT:    if (wait_q == '0) state_d = after_q;
            default:   state_d = S_WAIT;   // every other state issues one command
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_d    = CMD_NOP;
        ba_d     = '0;
        a_d      = '0;
        cke_d    = 1'b1;
        ack_d    = 1'b0;
        wait_ld  = 1'b0;
        wait_val = '0;
        after_d  = S_IDLE;
        lat_en   = 1'b0;
        wr_issue = 1'b0;
        rd_issue = 1'b0;
        pend_clr = 1'b0;
        case (state_q)
            S_PWRUP: cke_d = 1'b0;
            S_PRE1: begin
                cmd_d = CMD_PRE; a_d = A10;
                wait_ld = 1'b1; wait_val = W_RP; after_d = S_EMR;
            end
            S_EMR: begin
                // extended mode register: DLL enable
                cmd_d = CMD_LMR; ba_d = BA_W'(1);
                wait_ld = 1'b1; wait_val = W_MRD; after_d = S_MRS_DLL;
            end
            S_MRS_DLL: begin
                cmd_d = CMD_LMR; a_d = MODE_REG | DLL_RST;
                wait_ld = 1'b1; wait_val = W_MRD; after_d = S_PRE2;
            end
            S_PRE2: begin
                cmd_d = CMD_PRE; a_d = A10;
                wait_ld = 1'b1; wait_val = W_RP; after_d = S_REF1;
            end
            S_REF1: begin
                cmd_d = CMD_REF;
                wait_ld = 1'b1; wait_val = W_RFC; after_d = S_REF2;
            end
            S_REF2: begin
                cmd_d = CMD_REF;
                wait_ld = 1'b1; wait_val = W_RFC; after_d = S_MRS;
            end
            S_MRS: begin
                // final mode write also covers the DLL lock time
                cmd_d = CMD_LMR; a_d = MODE_REG;
                wait_ld = 1'b1; wait_val = W_LAST; after_d = S_IDLE;
            end
            S_REF: begin
                cmd_d = CMD_REF; pend_clr = 1'b1;
                wait_ld = 1'b1; wait_val = W_RFC; after_d = S_IDLE;
            end
            S_ACT: begin
                cmd_d = CMD_ACT; ba_d = req_bank; a_d = req_row; lat_en = 1'b1;
                wait_ld = 1'b1; wait_val = W_RCD; after_d = S_RW;
            end
            S_RW: begin
                // column with A10 set selects auto-precharge (closed page)
                cmd_d    = we_q ? CMD_WR : CMD_RD;
                ba_d     = bank_q;
                a_d      = ROW_W'(col_q) | A10;
                ack_d    = 1'b1;
                wr_issue = we_q;
                rd_issue = ~we_q;
                wait_ld  = 1'b1;
                wait_val = we_q ? W_WRAP : W_RDAP;
                after_d  = S_IDLE;
            end
            default: ;
        endcase
        init_d = init_q | (state_q == S_IDLE);
    end

    // ---------------- shared gap counter ----------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wait_q  <= W_INIT;
            after_q <= S_IDLE;
        end else if (wait_ld) begin
            wait_q  <= wait_val;
            after_q <= after_d;
        end else if (wait_q != '0) begin
            wait_q  <= wait_q - 1'b1;
        end
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bank_q <= '0;
            col_q  <= '0;
            we_q   <= 1'b0;
        end else if (lat_en) begin
            bank_q <= req_bank;
            col_q  <= req_col;
            we_q   <= bus.req_we_i;
        end
    end

    // ---------------- refresh interval ----------------
    // Free-running once IDLE is first reached, so refreshes keep their
    // cadence regardless of how long accesses take.
    assign ref_tick = (ref_run_q || state_q == S_IDLE) && (ref_cnt_q == '0);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ref_cnt_q <= REF_RELOAD;
            ref_run_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE) ref_run_q <= 1'b1;
            if (ref_run_q || state_q == S_IDLE) begin
                ref_cnt_q <= (ref_cnt_q == '0) ? REF_RELOAD : ref_cnt_q - 1'b1;
            end
            if (ref_tick)      pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;
        end
    end

    // ---------------- data-phase strobes ----------------
    // Shift registers run independently of the FSM so the read window
    // can spill into IDLE or the next ACT.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_sh_q <= '0;
            rd_sh_q <= '0;
            wr_ph_q <= 1'b0;
            rd_ph_q <= 1'b0;
        end else begin
            wr_sh_q <= {wr_sh_q[0], wr_issue};
            rd_sh_q <= {rd_sh_q[CL-1:0], rd_issue};
            wr_ph_q <= wr_sh_q[0] | wr_sh_q[1];
            rd_ph_q <= rd_sh_q[CL-1] | rd_sh_q[CL];
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cmd_q  <= CMD_NOP;
            ba_q   <= '0;
            a_q    <= '0;
            ce_q   <= 1'b0;
            cke_q  <= 1'b0;
            ack_q  <= 1'b0;
            init_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            ba_q   <= ba_d;
            a_q    <= a_d;
            ce_q   <= 1'b1;
            cke_q  <= cke_d;
            ack_q  <= ack_d;
            init_q <= init_d;
        end
    end

    assign bus.ctl_cs_no   = cmd_q[3];
    assign bus.ctl_ras_no  = cmd_q[2];
    assign bus.ctl_cas_no  = cmd_q[1];
    assign bus.ctl_we_no   = cmd_q[0];
    assign bus.ctl_ba_o    = ba_q;
    assign bus.ctl_a_o     = a_q;
    assign bus.ctl_ce_o    = ce_q;
    assign bus.ctl_cke_o   = cke_q;
    assign bus.ack_o       = ack_q;
    assign bus.init_done_o = init_q;
    assign bus.wr_phase_o  = wr_ph_q;
    assign bus.rd_phase_o  = rd_ph_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed bench for ddr_cmd_sched: init order/timing, write, read, refresh, refresh/request collision, mid-access reset.
// Latency: cycle numbers count posedges after reset release; outputs sampled 1 time unit after each posedge.
// Backpressure: client holds req_i until ack_o is seen.
module tb_ddr_cmd_sched;

    localparam int BA_W = 2, ROW_W = 13, COL_W = 10;
    localparam int T_INIT = 10, T_DLL = 8, T_REFI = 60;
    localparam int T_RFC = 9, T_RCD = 2, CL = 2, T_WRAP = 5;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [1:0] ba;
        logic [12:0] a;
    } ent_t;

    logic clock_i  = 1'b0;
    logic reset_ni = 1'b0;

    ddr_cmd_sched_if #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    ddr_cmd_sched #(.T_INIT(T_INIT), .T_DLL(T_DLL), .T_REFI(T_REFI)) dut (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    always #5 clock_i = ~clock_i;

    ent_t log_q[$];
    int   ack_q[$];
    int   wr_q[$];
    int   rd_q[$];
    int   cyc;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [3:0] cur_cmd();
        return {bus.ctl_cs_no, bus.ctl_ras_no, bus.ctl_cas_no, bus.ctl_we_no};
    endfunction

    function automatic ent_t get_ent(input int i);
        ent_t e;
        e.cyc = -1; e.cmd = NOP; e.ba = '0; e.a = '0;
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        ent_t e;
        @(posedge clock_i);
        #1;
        cyc++;
        if (cur_cmd() != NOP) begin
            e.cyc = cyc; e.cmd = cur_cmd(); e.ba = bus.ctl_ba_o; e.a = bus.ctl_a_o;
            log_q.push_back(e);
        end
        if (bus.ack_o)      ack_q.push_back(cyc);
        if (bus.wr_phase_o) wr_q.push_back(cyc);
        if (bus.rd_phase_o) rd_q.push_back(cyc);
    endtask

    task automatic clear_logs();
        log_q.delete(); ack_q.delete(); wr_q.delete(); rd_q.delete();
    endtask

    task automatic wait_acks(input int n, input int budget);
        for (int i = 0; i < budget && ack_q.size() < n; i++) step();
        chk("ack_seen", ack_q.size(), n);
    endtask

    // Release reset and check the whole power-up sequence.
    task automatic run_init();
        int         exp_cyc[7] = '{11, 13, 15, 17, 19, 28, 37};
        logic [3:0] exp_cmd[7] = '{PRE, LMR, LMR, PRE, REF, REF, LMR};
        int         exp_ba[7]  = '{0, 1, 0, 0, 0, 0, 0};
        int         exp_a[7]   = '{'h400, 'h000, 'h122, 'h400, 0, 0, 'h022};
        ent_t       e;
        clear_logs();
        reset_ni = 1'b1;
        cyc = 0;
        for (int i = 0; i < 100 && !bus.ctl_cke_o; i++) step();
        chk("cke_rise_cyc", cyc, T_INIT);
        chk("ce_at_cke", int'(bus.ctl_ce_o), 1);
        for (int i = 0; i < 200 && !bus.init_done_o; i++) step();
        chk("init_done_cyc", cyc, 45);
        chk("init_ncmd", log_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            e = get_ent(i);
            chk($sformatf("init%0d_cmd", i), int'(e.cmd), int'(exp_cmd[i]));
            chk($sformatf("init%0d_cyc", i), e.cyc, exp_cyc[i]);
            chk($sformatf("init%0d_ba", i), int'(e.ba), exp_ba[i]);
            if (exp_cmd[i] == LMR) chk($sformatf("init%0d_a", i), int'(e.a), exp_a[i]);
            if (exp_cmd[i] == PRE) chk($sformatf("init%0d_a10", i), int'(e.a[10]), 1);
        end
    endtask

    initial begin
        ent_t e0, e1, e2, e3;
        int   r, d;
        logic changed;

        bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
        cyc = 0;
        repeat (3) step();

        // reset state
        chk("rst_ce", int'(bus.ctl_ce_o), 0);
        chk("rst_cke", int'(bus.ctl_cke_o), 0);
        chk("rst_cmd", int'(cur_cmd()), int'(NOP));
        chk("rst_ba", int'(bus.ctl_ba_o), 0);
        chk("rst_a", int'(bus.ctl_a_o), 0);
        chk("rst_ack", int'(bus.ack_o), 0);
        chk("rst_init_done", int'(bus.init_done_o), 0);
        chk("rst_wr_phase", int'(bus.wr_phase_o), 0);
        chk("rst_rd_phase", int'(bus.rd_phase_o), 0);

        run_init();

        // write then read, read address changed after ACT
        clear_logs();
        bus.req_addr_i = {2'd2, 13'h1ABC, 10'h03F}; bus.req_we_i = 1'b1; bus.req_i = 1'b1;
        wait_acks(1, 40);
        bus.req_addr_i = {2'd1, 13'h0055, 10'h3FF}; bus.req_we_i = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 40 && ack_q.size() < 2; i++) begin
            step();
            if (!changed && log_q.size() >= 3) begin
                bus.req_addr_i = {2'd3, 13'h1FFF, 10'h000}; bus.req_we_i = 1'b1;
                changed = 1'b1;
            end
        end
        bus.req_i = 1'b0;
        repeat (6) step();
        e0 = get_ent(0); e1 = get_ent(1); e2 = get_ent(2); e3 = get_ent(3);
        chk("acc_ncmd", log_q.size(), 4);
        chk("wr_act_cmd", int'(e0.cmd), int'(ACT));
        chk("wr_act_ba", int'(e0.ba), 2);
        chk("wr_act_a", int'(e0.a), 'h1ABC);
        chk("wr_cmd", int'(e1.cmd), int'(WR));
        chk("wr_rcd", e1.cyc - e0.cyc, T_RCD);
        chk("wr_ba", int'(e1.ba), 2);
        chk("wr_a", int'(e1.a), 'h43F);
        chk("wr_ack_cyc", get_ent(1).cyc, (ack_q.size() > 0) ? ack_q[0] : -1);
        chk("wr_phase_n", wr_q.size(), 2);
        chk("wr_phase_0", (wr_q.size() > 0) ? wr_q[0] : -1, e1.cyc + 1);
        chk("wr_phase_1", (wr_q.size() > 1) ? wr_q[1] : -1, e1.cyc + 2);
        chk("wr_gap_ok", int'(e2.cyc - e1.cyc >= T_WRAP), 1);
        chk("rd_act_cmd", int'(e2.cmd), int'(ACT));
        chk("rd_act_ba", int'(e2.ba), 1);
        chk("rd_act_a", int'(e2.a), 'h0055);
        chk("rd_cmd", int'(e3.cmd), int'(RD));
        chk("rd_ba", int'(e3.ba), 1);
        chk("rd_a", int'(e3.a), 'h7FF);
        chk("rd_ack_cyc", (ack_q.size() > 1) ? ack_q[1] : -1, e3.cyc);
        chk("ack_count", ack_q.size(), 2);
        chk("rd_phase_n", rd_q.size(), 2);
        chk("rd_phase_0", (rd_q.size() > 0) ? rd_q[0] : -1, e3.cyc + CL);
        chk("rd_phase_1", (rd_q.size() > 1) ? rd_q[1] : -1, e3.cyc + CL + 1);

        // idle: only refreshes, at the refresh interval
        clear_logs();
        for (int i = 0; i < 300 && log_q.size() < 3; i++) step();
        chk("idle_nref", log_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("idle%0d_is_ref", i), int'(get_ent(i).cmd), int'(REF));
        for (int i = 1; i < 3; i++) begin
            d = get_ent(i).cyc - get_ent(i - 1).cyc;
            chk($sformatf("refi_%0d_in_range", i), int'(d >= T_REFI && d <= T_REFI + T_RFC), 1);
        end
        chk("idle_no_ack", ack_q.size(), 0);
        r = get_ent(2).cyc;

        // request raised in the cycle the next refresh becomes pending
        for (int i = 0; i < 100 && cyc < r + 58; i++) step();
        clear_logs();
        bus.req_addr_i = {2'd0, 13'h0001, 10'h001}; bus.req_we_i = 1'b0; bus.req_i = 1'b1;
        wait_acks(1, 40);
        bus.req_i = 1'b0;
        e0 = get_ent(0); e1 = get_ent(1);
        chk("coll_first_ref", int'(e0.cmd), int'(REF));
        chk("coll_then_act", int'(e1.cmd), int'(ACT));
        chk("coll_rfc_ok", int'(e1.cyc - e0.cyc >= T_RFC), 1);
        d = ((ack_q.size() > 0) ? ack_q[0] : 0) - e0.cyc;
        chk("coll_ack_delay_ok", int'(d >= T_RFC + T_RCD && d <= T_RFC + T_RCD + 1), 1);
        chk("coll_ack_after_act", ((ack_q.size() > 0) ? ack_q[0] : 0) - e1.cyc, T_RCD);

        // reset during the T_RCD wait
        clear_logs();
        bus.req_addr_i = {2'd3, 13'h0777, 10'h011}; bus.req_we_i = 1'b1; bus.req_i = 1'b1;
        for (int i = 0; i < 40 && log_q.size() < 1; i++) step();
        chk("mid_act_seen", int'(get_ent(0).cmd), int'(ACT));
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_cmd", int'(cur_cmd()), int'(NOP));
        chk("mid_rst_cke", int'(bus.ctl_cke_o), 0);
        chk("mid_rst_ce", int'(bus.ctl_ce_o), 0);
        chk("mid_rst_init_done", int'(bus.init_done_o), 0);
        bus.req_i = 1'b0;
        clear_logs();
        repeat (4) step();
        chk("mid_rst_no_cmd", log_q.size(), 0);
        chk("mid_rst_no_ack", ack_q.size(), 0);
        run_init();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
